// File: rtl/led_pkg.sv
// led_pkg: shared types and widths for the led_blinker slice.
// Holds the per-channel mode encoding, the phase/PWM counter widths and the
// helper that turns a mode plus the shared phase into a "lit" level.
package led_pkg;

  typedef enum logic [1:0] {
    LED_OFF        = 2'b00,
    LED_ON         = 2'b01,
    LED_BLINK_FAST = 2'b10,
    LED_BLINK_SLOW = 2'b11
  } led_mode_t;

  localparam int LED_PHASE_W = 2;
  localparam int LED_PWM_W   = 4;

  // Fast blink follows phase bit 0 (period 2 ticks), slow blink follows
  // phase bit 1 (period 4 ticks), so every channel stays phase-aligned.
  function automatic logic led_lit(input led_mode_t m,
                                   input logic [LED_PHASE_W-1:0] ph);
    logic lit;
    lit = 1'b0;
    case (m)
      LED_OFF:        lit = 1'b0;
      LED_ON:         lit = 1'b1;
      LED_BLINK_FAST: lit = ph[0];
      LED_BLINK_SLOW: lit = ph[1];
      default:        lit = 1'b0;
    endcase
    return lit;
  endfunction

endpackage

// File: rtl/led_prescaler.sv
// led_prescaler: divides int_osc down to a one-cycle tick every TOGGLE_DIV
// enabled cycles. Dropping en freezes the count, so a tick that lands on a
// disabled cycle is held back and fires on the first enabled cycle instead.
module led_prescaler
  import led_pkg::*;
#(
  parameter int TOGGLE_DIV = 10_000_000
) (
  input  logic int_osc,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int               CNT_W   = (TOGGLE_DIV > 1) ? $clog2(TOGGLE_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TOGGLE_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = en && (cnt == CNT_MAX);

  // Count 0..TOGGLE_DIV-1 while enabled, wrap on the tick cycle, hold otherwise.
  always_ff @(posedge int_osc or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (en) begin
      if (tick) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/led_blinker.sv
// led_blinker: multi-channel LED driver. Switch modes are synchronised, a
// shared phase counter advances on each prescaler tick, and each channel's
// LED is registered from its decoded mode and the current phase.
// Optional feature macro: LED_BLINKER_DIM_EN adds a duty input and a
// free-running 4-bit PWM that gates every lit level for dimming.
module led_blinker
  import led_pkg::*;
#(
  parameter int NUM_CH     = 3,
  parameter int TOGGLE_DIV = 10_000_000
) (
  input  logic                  int_osc,
  input  logic                  reset,
  input  logic                  en,
  input  logic [2*NUM_CH-1:0]   mode,
`ifdef LED_BLINKER_DIM_EN
  input  logic [LED_PWM_W-1:0]  duty,
`endif
  output logic                  tick,
  output logic [NUM_CH-1:0]     led
);

  logic [2*NUM_CH-1:0]    mode_meta;
  logic [2*NUM_CH-1:0]    mode_sync;
  logic [LED_PHASE_W-1:0] phase;
  logic [NUM_CH-1:0]      lit;
  logic                   gate;

  led_prescaler #(
    .TOGGLE_DIV (TOGGLE_DIV)
  ) u_prescaler (
    .int_osc (int_osc),
    .reset   (reset),
    .en      (en),
    .tick    (tick)
  );

  // Two-flop synchroniser on every mode bit; the switches are asynchronous.
  always_ff @(posedge int_osc or negedge reset) begin
    if (!reset) begin
      mode_meta <= '0;
      mode_sync <= '0;
    end else begin
      mode_meta <= mode;
      mode_sync <= mode_meta;
    end
  end

  // Shared blink phase, advanced once per tick and wrapping 3 -> 0.
  always_ff @(posedge int_osc or negedge reset) begin
    if (!reset) begin
      phase <= '0;
    end else if (tick) begin
      phase <= phase + LED_PHASE_W'(1);
    end
  end

  // Per-channel decode of the synchronised mode against the current phase.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign lit[i] = led_lit(led_mode_t'(mode_sync[2*i +: 2]), phase);
  end

`ifdef LED_BLINKER_DIM_EN
  logic [LED_PWM_W-1:0] pwm;

  // Free-running PWM counter; runs regardless of en so dimming never stalls.
  always_ff @(posedge int_osc or negedge reset) begin
    if (!reset) begin
      pwm <= '0;
    end else begin
      pwm <= pwm + LED_PWM_W'(1);
    end
  end

  assign gate = (pwm < duty);
`else
  assign gate = 1'b1;
`endif

  // Output register: a lit level drives the pin only while the gate is open.
  always_ff @(posedge int_osc or negedge reset) begin
    if (!reset) begin
      led <= '0;
    end else begin
      led <= lit & {NUM_CH{gate}};
    end
  end

endmodule

// File: tb/tb_led_blinker.sv
// tb_led_blinker: directed self-checking bench for led_blinker with
// TOGGLE_DIV=4 and NUM_CH=3. Outputs are sampled 1 time unit after each
// rising edge of int_osc.
module tb_led_blinker;

  localparam int NUM_CH     = 3;
  localparam int TOGGLE_DIV = 4;

  logic                int_osc = 1'b0;
  logic                reset   = 1'b0;
  logic                en      = 1'b0;
  logic [2*NUM_CH-1:0] mode    = '0;
`ifdef LED_BLINKER_DIM_EN
  logic [3:0]          duty    = '0;
`endif
  logic                tick;
  logic [NUM_CH-1:0]   led;

  int vectors     = 0;
  int miscompares = 0;

  always #5 int_osc = ~int_osc;

  led_blinker #(
    .NUM_CH     (NUM_CH),
    .TOGGLE_DIV (TOGGLE_DIV)
  ) dut (
    .int_osc (int_osc),
    .reset   (reset),
    .en      (en),
    .mode    (mode),
`ifdef LED_BLINKER_DIM_EN
    .duty    (duty),
`endif
    .tick    (tick),
    .led     (led)
  );

  task automatic next_edge;
    @(posedge int_osc);
    #1;
  endtask

`ifndef LED_BLINKER_DIM_EN
  // Reset clears outputs; mode=ON on all channels shows on the 3rd edge.
  task automatic test_reset;
    logic [2:0] exp_led;
    reset = 1'b0;
    en    = 1'b0;
    mode  = 6'b111111;
    repeat (3) next_edge;
    vectors++;
    if (led !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL reset_led: got %b expected %b", led, 3'b000);
    end
    vectors++;
    if (tick !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_tick: got %b expected %b", tick, 1'b0);
    end
    reset = 1'b1;
    mode  = 6'b010101;
    for (int e = 1; e <= 3; e++) begin
      next_edge;
      exp_led = (e == 3) ? 3'b111 : 3'b000;
      vectors++;
      if (led !== exp_led) begin
        miscompares++;
        $display("[TB] FAIL release_led edge %0d: got %b expected %b", e, led, exp_led);
      end
    end
  endtask

  // ch0 fast, ch1 slow, ch2 off: tick every 4 cycles, led follows phase.
  task automatic test_blink;
    logic [1:0] p;
    logic [2:0] exp_led;
    logic       exp_tick;
    en   = 1'b0;
    mode = 6'b00_11_10;
    repeat (3) next_edge;
    vectors++;
    if (led !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL blink_start_led: got %b expected %b", led, 3'b000);
    end
    en = 1'b1;
    for (int k = 1; k <= 39; k++) begin
      next_edge;
      exp_tick = ((k % 4) == 3);
      p        = 2'((k - 1) / 4);
      exp_led  = {1'b0, p[1], p[0]};
      vectors++;
      if (tick !== exp_tick) begin
        miscompares++;
        $display("[TB] FAIL blink_tick k=%0d: got %b expected %b", k, tick, exp_tick);
      end
      vectors++;
      if (led !== exp_led) begin
        miscompares++;
        $display("[TB] FAIL blink_led k=%0d: got %b expected %b", k, led, exp_led);
      end
    end
  endtask

  // en dropped during a tick cycle: tick suppressed, led frozen, resume ticks.
  task automatic test_en_freeze;
    en = 1'b0;
    #1;
    vectors++;
    if (tick !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL freeze_tick_drop: got %b expected %b", tick, 1'b0);
    end
    for (int c = 1; c <= 10; c++) begin
      next_edge;
      vectors++;
      if (tick !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL freeze_tick c=%0d: got %b expected %b", c, tick, 1'b0);
      end
      vectors++;
      if (led !== 3'b001) begin
        miscompares++;
        $display("[TB] FAIL freeze_led c=%0d: got %b expected %b", c, led, 3'b001);
      end
    end
    en = 1'b1;
    #1;
    vectors++;
    if (tick !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL resume_tick: got %b expected %b", tick, 1'b1);
    end
    next_edge;
    vectors++;
    if (tick !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL resume_tick_after: got %b expected %b", tick, 1'b0);
    end
    vectors++;
    if (led !== 3'b001) begin
      miscompares++;
      $display("[TB] FAIL resume_led_hold: got %b expected %b", led, 3'b001);
    end
    next_edge;
    vectors++;
    if (led !== 3'b010) begin
      miscompares++;
      $display("[TB] FAIL resume_led_phase2: got %b expected %b", led, 3'b010);
    end
  endtask

  // Asynchronous reset while led is lit and phase is 3, then first tick timing.
  task automatic test_reset_mid_blink;
    logic [2:0] exp_led;
    logic       exp_tick;
    repeat (4) next_edge;
    vectors++;
    if (led !== 3'b011) begin
      miscompares++;
      $display("[TB] FAIL midblink_pre_led: got %b expected %b", led, 3'b011);
    end
    vectors++;
    if (dut.phase !== 2'd3) begin
      miscompares++;
      $display("[TB] FAIL midblink_pre_phase: got %0d expected %0d", dut.phase, 3);
    end
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if (led !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL async_led: got %b expected %b", led, 3'b000);
    end
    vectors++;
    if (dut.phase !== 2'd0) begin
      miscompares++;
      $display("[TB] FAIL async_phase: got %0d expected %0d", dut.phase, 0);
    end
    vectors++;
    if (dut.u_prescaler.cnt !== 2'd0) begin
      miscompares++;
      $display("[TB] FAIL async_cnt: got %0d expected %0d", dut.u_prescaler.cnt, 0);
    end
    next_edge;
    reset = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      next_edge;
      exp_tick = (e == 3);
      exp_led  = (e == 5) ? 3'b001 : 3'b000;
      vectors++;
      if (tick !== exp_tick) begin
        miscompares++;
        $display("[TB] FAIL post_reset_tick e=%0d: got %b expected %b", e, tick, exp_tick);
      end
      vectors++;
      if (led !== exp_led) begin
        miscompares++;
        $display("[TB] FAIL post_reset_led e=%0d: got %b expected %b", e, led, exp_led);
      end
    end
  endtask

  // ch0 OFF -> BLINK_SLOW at phase 2 lights three edges later, no tick needed.
  task automatic test_mode_change;
    logic [2:0] exp_led;
    reset = 1'b0;
    mode  = 6'b00_11_00;
    en    = 1'b1;
    next_edge;
    reset = 1'b1;
    repeat (8) next_edge;
    en = 1'b0;
    vectors++;
    if (dut.phase !== 2'd2) begin
      miscompares++;
      $display("[TB] FAIL modechg_phase: got %0d expected %0d", dut.phase, 2);
    end
    vectors++;
    if (led !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL modechg_led_pre: got %b expected %b", led, 3'b000);
    end
    next_edge;
    vectors++;
    if (led !== 3'b010) begin
      miscompares++;
      $display("[TB] FAIL modechg_led_ch1: got %b expected %b", led, 3'b010);
    end
    mode = 6'b00_11_11;
    for (int e = 1; e <= 3; e++) begin
      next_edge;
      exp_led = (e == 3) ? 3'b011 : 3'b010;
      vectors++;
      if (led !== exp_led) begin
        miscompares++;
        $display("[TB] FAIL modechg_led e=%0d: got %b expected %b", e, led, exp_led);
      end
    end
  endtask

  // Without dimming, ON is a solid 1 every cycle.
  task automatic test_lit_solid;
    mode = 6'b00_00_01;
    en   = 1'b0;
    repeat (3) next_edge;
    for (int c = 1; c <= 8; c++) begin
      next_edge;
      vectors++;
      if (led !== 3'b001) begin
        miscompares++;
        $display("[TB] FAIL solid_led c=%0d: got %b expected %b", c, led, 3'b001);
      end
    end
  endtask
`else
  // Dimming: duty=4 lights ch0 4 of 16 cycles; duty=0 keeps it dark.
  task automatic test_dim;
    int highs;
    reset = 1'b0;
    en    = 1'b0;
    duty  = 4'd4;
    mode  = 6'b00_00_01;
    next_edge;
    vectors++;
    if (led !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL dim_reset_led: got %b expected %b", led, 3'b000);
    end
    vectors++;
    if (tick !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL dim_reset_tick: got %b expected %b", tick, 1'b0);
    end
    reset = 1'b1;
    repeat (3) next_edge;
    highs = 0;
    for (int c = 0; c < 16; c++) begin
      next_edge;
      if (led[0] === 1'b1) highs++;
      vectors++;
      if (led[2:1] !== 2'b00) begin
        miscompares++;
        $display("[TB] FAIL dim_other_ch c=%0d: got %b expected %b", c, led[2:1], 2'b00);
      end
    end
    vectors++;
    if (highs !== 4) begin
      miscompares++;
      $display("[TB] FAIL dim_duty4_count: got %0d expected %0d", highs, 4);
    end
    duty = 4'd0;
    next_edge;
    for (int c = 0; c < 16; c++) begin
      next_edge;
      vectors++;
      if (led[0] !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL dim_duty0 c=%0d: got %b expected %b", c, led[0], 1'b0);
      end
    end
  endtask
`endif

  // Run every scenario in order, then print the summary.
  initial begin
    $display("[TB] tb_led_blinker start");
`ifndef LED_BLINKER_DIM_EN
    test_reset;
    test_blink;
    test_en_freeze;
    test_reset_mid_blink;
    test_mode_change;
    test_lit_solid;
`else
    test_dim;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
